// File: rtl/ads1292_spi_responder.sv
// ADS1292 SPI responder: register file, command decoder and sample streaming,
// all clocked on i_CLK with the SPI pins oversampled through synchronizers.
`timescale 1ns/1ps
module ads1292_spi_responder #(
    parameter int unsigned DRDY_PERIOD = 100000,
    parameter logic [7:0]  ID_VALUE    = 8'h73
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_SPI_CLK,
    input  logic        i_SPI_CSN,
    input  logic        i_SPI_MOSI,
    output logic        o_SPI_MISO,
    input  logic        i_ADS1292_START,
    input  logic        i_ADS1292_RESETN,
    output logic        o_ADS1292_DRDY,
    input  logic [71:0] i_SAMPLE_DATA,
    output logic        o_SAMPLE_TAKEN,
    output logic        o_OVERRUN,
    output logic        o_RDATAC
);

    localparam int CNT_W = (DRDY_PERIOD > 2) ? $clog2(DRDY_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRDY_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DRDY_PERIOD - 2);

    typedef enum logic [2:0] {ST_IDLE, ST_ARG, ST_WDATA, ST_RDOUT, ST_STREAM} state_t;

    function automatic logic [7:0] reg_default(input logic [3:0] a);
        case (a)
            4'h0:    return ID_VALUE;
            4'h1:    return 8'h02;
            4'h2:    return 8'h80;
            4'h3:    return 8'h10;
            4'h9:    return 8'h02;
            4'hA:    return 8'h05;
            4'hB:    return 8'h0C;
            default: return 8'h00;
        endcase
    endfunction

    // [0] metastable stage, [1] synchronized value, [2] previous synchronized value
    logic [2:0] sclk_sync_q, csn_sync_q;
    logic [1:0] mosi_sync_q, rstn_sync_q;

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '0;
            mosi_sync_q <= '0;
            rstn_sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value, so the chain shifts by one stage per clock.
            sclk_sync_q <= {sclk_sync_q[1:0], i_SPI_CLK};
            csn_sync_q  <= {csn_sync_q[1:0], i_SPI_CSN};
            mosi_sync_q <= {mosi_sync_q[0], i_SPI_MOSI};
            rstn_sync_q <= {rstn_sync_q[0], i_ADS1292_RESETN};
        end
    end

    logic sclk_rise, sclk_fall, csn_high, csn_fall, mosi_bit, soft_rst;
    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign csn_high  = csn_sync_q[1];
    assign csn_fall  = csn_sync_q[2] & ~csn_sync_q[1];
    assign mosi_bit  = mosi_sync_q[1];
    assign soft_rst  = ~rstn_sync_q[1];

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       rx_q, rx_d;
    logic [7:0]       tx_q, tx_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       count_q, count_d;
    logic             is_read_q, is_read_d;
    logic [6:0]       stream_cnt_q, stream_cnt_d;
    logic             miso_q, miso_d;
    logic [7:0]       regs_q [12];
    logic [7:0]       regs_d [12];
    logic             rdatac_q, rdatac_d;
    logic             start_flag_q, start_flag_d;
    logic [CNT_W-1:0] drdy_cnt_q, drdy_cnt_d;
    logic             drdy_q, drdy_d;
    logic [71:0]      shadow_q, shadow_d;
    logic             new_data_q, new_data_d;
    logic             armed_q, armed_d;
    logic             taken_q, taken_d;
    logic             overrun_q, overrun_d;

    function automatic logic [7:0] reg_read(input logic [7:0] a);
        if (a <= 8'd11) return regs_q[a[3:0]];
        return 8'h00;
    endfunction

    logic [7:0] rx_byte;
    logic [6:0] stream_idx;
    logic       byte_done, cmd_reset, start_eff, fire, streaming;

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_d         = rx_q;
        tx_d         = tx_q;
        addr_d       = addr_q;
        count_d      = count_q;
        is_read_d    = is_read_q;
        stream_cnt_d = stream_cnt_q;
        miso_d       = miso_q;
        regs_d       = regs_q;
        rdatac_d     = rdatac_q;
        start_flag_d = start_flag_q;
        drdy_cnt_d   = drdy_cnt_q;
        drdy_d       = drdy_q;
        shadow_d     = shadow_q;
        new_data_d   = new_data_q;
        armed_d      = armed_q;
        taken_d      = 1'b0;
        overrun_d    = 1'b0;
        rx_byte      = {rx_q, mosi_bit};
        stream_idx   = 7'd71 - stream_cnt_q;
        byte_done    = 1'b0;
        cmd_reset    = 1'b0;
        start_eff    = i_ADS1292_START | start_flag_q;
        fire         = start_eff && (drdy_cnt_q == CNT_LAST);
        streaming    = (state_q == ST_STREAM) && (stream_cnt_q < 7'd72);

        if (csn_high) begin
            armed_d   = 1'b1;
            state_d   = ST_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
        end else if (armed_q) begin
            if (csn_fall && rdatac_q && new_data_q) begin
                state_d      = ST_STREAM;
                stream_cnt_d = 7'd0;
                new_data_d   = 1'b0;
            end
            if (sclk_rise) begin
                case (state_q)
                    ST_RDOUT: begin
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    ST_STREAM: begin
                        miso_d = streaming ? shadow_q[stream_idx] : 1'b0;
                        if (streaming) stream_cnt_d = stream_cnt_q + 7'd1;
                    end
                    default: miso_d = 1'b0;
                endcase
            end
            if (sclk_fall) begin
                drdy_d    = 1'b1;
                bit_cnt_d = bit_cnt_q + 3'd1;
                rx_d      = rx_byte[6:0];
                byte_done = (bit_cnt_q == 3'd7);
            end
        end

        if (byte_done) begin
            case (state_q)
                ST_IDLE: begin
                    case (rx_byte)
                        8'h06: cmd_reset = 1'b1;
                        8'h08: start_flag_d = 1'b1;
                        8'h0A: start_flag_d = 1'b0;
                        8'h10: rdatac_d = 1'b1;
                        8'h11: rdatac_d = 1'b0;
                        8'h12: begin
                            state_d      = ST_STREAM;
                            stream_cnt_d = 7'd0;
                            new_data_d   = 1'b0;
                        end
                        default: begin
                            if (!rdatac_q && (rx_byte[7:6] == 2'b00 || rx_byte[7:6] == 2'b01)
                                && (rx_byte[5] ^ rx_byte[6])) begin
                                state_d   = ST_ARG;
                                is_read_d = (rx_byte[7:5] == 3'b001);
                                addr_d    = {3'b000, rx_byte[4:0]};
                            end
                        end
                    endcase
                end
                ST_ARG: begin
                    count_d = rx_byte;
                    if (is_read_q) begin
                        state_d = ST_RDOUT;
                        tx_d    = reg_read(addr_q);
                    end else begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (addr_q >= 8'd1 && addr_q <= 8'd11) regs_d[addr_q[3:0]] = rx_byte;
                    addr_d = addr_q + 8'd1;
                    if (count_q == 8'd0) state_d = ST_IDLE;
                    else count_d = count_q - 8'd1;
                end
                ST_RDOUT: begin
                    addr_d = addr_q + 8'd1;
                    if (count_q == 8'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        count_d = count_q - 8'd1;
                        tx_d    = reg_read(addr_q + 8'd1);
                    end
                end
                ST_STREAM: begin
                    case (rx_byte)
                        8'h06:   cmd_reset = 1'b1;
                        8'h0A:   start_flag_d = 1'b0;
                        8'h11:   rdatac_d = 1'b0;
                        default: ;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Sample timer: DRDY is released one cycle before each fire so every sample gives a fresh falling edge.
        if (!start_eff || fire) drdy_cnt_d = '0;
        else drdy_cnt_d = drdy_cnt_q + CNT_W'(1);
        if (start_eff && drdy_cnt_q == CNT_PRE) drdy_d = 1'b1;
        if (fire) begin
            if (streaming) begin
                overrun_d = 1'b1;
            end else begin
                shadow_d   = i_SAMPLE_DATA;
                taken_d    = 1'b1;
                drdy_d     = 1'b0;
                new_data_d = 1'b1;
            end
        end

        if (cmd_reset) begin
            for (int i = 0; i < 12; i++) regs_d[i] = reg_default(4'(i));
            rdatac_d     = 1'b1;
            start_flag_d = 1'b0;
            drdy_cnt_d   = '0;
            state_d      = ST_IDLE;
        end

        if (soft_rst) begin
            for (int i = 0; i < 12; i++) regs_d[i] = reg_default(4'(i));
            state_d      = ST_IDLE;
            bit_cnt_d    = 3'd0;
            rx_d         = 7'd0;
            tx_d         = 8'd0;
            addr_d       = 8'd0;
            count_d      = 8'd0;
            is_read_d    = 1'b0;
            stream_cnt_d = 7'd0;
            miso_d       = 1'b0;
            rdatac_d     = 1'b1;
            start_flag_d = 1'b0;
            drdy_cnt_d   = '0;
            drdy_d       = 1'b1;
            shadow_d     = 72'd0;
            new_data_d   = 1'b0;
            armed_d      = 1'b0;
            taken_d      = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            rx_q         <= 7'd0;
            tx_q         <= 8'd0;
            addr_q       <= 8'd0;
            count_q      <= 8'd0;
            is_read_q    <= 1'b0;
            stream_cnt_q <= 7'd0;
            miso_q       <= 1'b0;
            // NOTE: the register file is tiny and has architectural reset values, so it is built from resettable flops rather than RAM.
            for (int i = 0; i < 12; i++) regs_q[i] <= reg_default(4'(i));
            rdatac_q     <= 1'b1;
            start_flag_q <= 1'b0;
            drdy_cnt_q   <= '0;
            drdy_q       <= 1'b1;
            shadow_q     <= 72'd0;
            new_data_q   <= 1'b0;
            armed_q      <= 1'b0;
            taken_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            is_read_q    <= is_read_d;
            stream_cnt_q <= stream_cnt_d;
            miso_q       <= miso_d;
            regs_q       <= regs_d;
            rdatac_q     <= rdatac_d;
            start_flag_q <= start_flag_d;
            drdy_cnt_q   <= drdy_cnt_d;
            drdy_q       <= drdy_d;
            shadow_q     <= shadow_d;
            new_data_q   <= new_data_d;
            armed_q      <= armed_d;
            taken_q      <= taken_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_SPI_MISO     = miso_q;
    assign o_ADS1292_DRDY = drdy_q;
    assign o_SAMPLE_TAKEN = taken_q;
    assign o_OVERRUN      = overrun_q;
    assign o_RDATAC       = rdatac_q;

endmodule

// File: tb/tb_ads1292_spi_responder.sv
// Directed bench for ads1292_spi_responder: register access, sample timing,
// 72-bit streaming, overrun, partial frames and both reset commands.
`timescale 1ns/1ps
module tb_ads1292_spi_responder;

    localparam int HALF = 8;
    localparam logic [71:0] FRAME_A = 72'hC00000_123456_ABCDEF;
    localparam logic [71:0] FRAME_B = 72'h800000_0F0F0F_F0F0F0;
    localparam logic [71:0] FRAME_C = 72'h7FFFFF_AAAAAA_555555;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_clk = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        start = 1'b0;
    logic        resetn = 1'b1;
    logic [71:0] sample = 72'd0;
    logic        spi_miso, drdy, taken, overrun, rdatac;

    int checks = 0;
    int errors = 0;
    int ovr_cycles = 0;
    int ovr_pulses = 0;
    logic ovr_prev = 1'b0;

    always #5 clk = ~clk;

    ads1292_spi_responder #(.DRDY_PERIOD(50), .ID_VALUE(8'h73)) dut (
        .i_CLK            (clk),
        .i_RST            (rst),
        .i_SPI_CLK        (spi_clk),
        .i_SPI_CSN        (spi_csn),
        .i_SPI_MOSI       (spi_mosi),
        .o_SPI_MISO       (spi_miso),
        .i_ADS1292_START  (start),
        .i_ADS1292_RESETN (resetn),
        .o_ADS1292_DRDY   (drdy),
        .i_SAMPLE_DATA    (sample),
        .o_SAMPLE_TAKEN   (taken),
        .o_OVERRUN        (overrun),
        .o_RDATAC         (rdatac)
    );

    always @(negedge clk) begin
        if (overrun) begin
            ovr_cycles++;
            if (!ovr_prev) ovr_pulses++;
        end
        ovr_prev = overrun;
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic mo, output logic mi);
        spi_clk  = 1'b1;
        spi_mosi = mo;
        wait_clks(HALF);
        mi      = spi_miso;
        spi_clk = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], b);
            rx[i] = b;
        end
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic csn_high();
        wait_clks(HALF);
        spi_csn = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic cmd(input logic [7:0] op);
        logic [7:0] r;
        csn_low();
        spi_byte(op, r);
        csn_high();
    endtask

    task automatic read_bits(input int n, output logic [79:0] d);
        logic b;
        d = 80'd0;
        for (int i = 0; i < n; i++) begin
            spi_bit(1'b0, b);
            d = {d[78:0], b};
        end
    endtask

    task automatic wait_drdy_low(output int n);
        n = 0;
        do begin
            wait_clks(1);
            n++;
        end while (drdy !== 1'b0 && n < 200);
    endtask

    initial begin
        logic [7:0]  r0, r1, r2, junk;
        logic [79:0] d;
        logic        b0;
        int          n, pulses0, cycles0;

        wait_clks(5);
        rst = 1'b0;
        wait_clks(5);
        check("rst_drdy", drdy, 1'b1);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_rdatac", rdatac, 1'b1);
        check("rst_taken", taken, 1'b0);
        check("rst_overrun", overrun, 1'b0);

        cmd(8'h11);
        check("sdatac", rdatac, 1'b0);
        csn_low(); spi_byte(8'h20, junk); spi_byte(8'h00, junk); spi_byte(8'h00, r0); csn_high();
        check("id_read", r0, 8'h73);

        csn_low(); spi_byte(8'h41, junk); spi_byte(8'h01, junk);
        spi_byte(8'hA5, junk); spi_byte(8'h3C, junk); csn_high();
        csn_low(); spi_byte(8'h21, junk); spi_byte(8'h01, junk);
        spi_byte(8'h00, r0); spi_byte(8'h00, r1); csn_high();
        check("wreg_rd_01", r0, 8'hA5);
        check("wreg_rd_02", r1, 8'h3C);

        csn_low(); spi_byte(8'h40, junk); spi_byte(8'h00, junk); spi_byte(8'h55, junk); csn_high();
        csn_low(); spi_byte(8'h20, junk); spi_byte(8'h00, junk); spi_byte(8'h00, r0); csn_high();
        check("id_write_ignored", r0, 8'h73);

        csn_low(); spi_byte(8'h2B, junk); spi_byte(8'h02, junk);
        spi_byte(8'h00, r0); spi_byte(8'h00, r1); spi_byte(8'h00, r2); csn_high();
        check("rd_0b", r0, 8'h0C);
        check("rd_0c", r1, 8'h00);
        check("rd_0d", r2, 8'h00);

        csn_low(); spi_byte(8'h41, junk); spi_byte(8'h00, junk);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, b0);
        csn_high();
        csn_low(); spi_byte(8'h21, junk); spi_byte(8'h00, junk); spi_byte(8'h00, r0); csn_high();
        check("partial_wr_discarded", r0, 8'hA5);

        cmd(8'h10);
        check("rdatac_on", rdatac, 1'b1);

        sample = FRAME_A;
        start  = 1'b1;
        wait_drdy_low(n);
        start = 1'b0;
        check("drdy_latency", n, 50);
        check("sample_taken", taken, 1'b1);

        csn_low();
        spi_clk  = 1'b1;
        spi_mosi = 1'b0;
        wait_clks(HALF);
        check("drdy_before_fall", drdy, 1'b0);
        b0      = spi_miso;
        spi_clk = 1'b0;
        wait_clks(HALF);
        check("drdy_after_fall", drdy, 1'b1);
        read_bits(79, d);
        csn_high();
        d = {b0, d[78:0]};
        check("stream_status", d[79:56], 24'hC00000);
        check("stream_ch1", d[55:32], 24'h123456);
        check("stream_ch2", d[31:8], 24'hABCDEF);
        check("stream_tail", d[7:0], 8'h00);

        pulses0 = ovr_pulses;
        cycles0 = ovr_cycles;
        sample  = FRAME_B;
        start   = 1'b1;
        wait_drdy_low(n);
        sample = FRAME_C;
        check("drdy_latency_2", n, 50);
        csn_low();
        read_bits(72, d);
        start = 1'b0;
        csn_high();
        check("overrun_frame_kept", d[71:0], FRAME_B);
        check("overrun_seen", (ovr_pulses - pulses0) > 0, 1'b1);
        check("overrun_one_cycle", ovr_cycles - cycles0, ovr_pulses - pulses0);

        cmd(8'h11);
        cmd(8'h11);
        check("sdatac_again", rdatac, 1'b0);
        cmd(8'h06);
        check("reset_cmd_rdatac", rdatac, 1'b1);
        cmd(8'h11);
        csn_low(); spi_byte(8'h21, junk); spi_byte(8'h00, junk); spi_byte(8'h00, r0); csn_high();
        check("reset_cmd_default", r0, 8'h02);

        csn_low(); spi_byte(8'h41, junk); spi_byte(8'h00, junk); spi_byte(8'h77, junk); csn_high();
        resetn = 1'b0;
        wait_clks(5);
        resetn = 1'b1;
        wait_clks(5);
        check("resetn_rdatac", rdatac, 1'b1);
        check("resetn_drdy", drdy, 1'b1);
        cmd(8'h11);
        csn_low(); spi_byte(8'h21, junk); spi_byte(8'h00, junk); spi_byte(8'h00, r0); csn_high();
        check("resetn_default", r0, 8'h02);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
